dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DBITS, default 32: data and address width.
REQ-002 Parameter MAX_WAIT, default 4: number of consecutive denied debug cycles before the debug port forces a steal cycle; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port cpu_req, input, 1: pipeline stage 2 accesses memory this cycle (load or store).
REQ-006 Port cpu_wr, input, 1: the CPU access is a store.
REQ-007 Port cpu_addr / cpu_wdata, input, DBITS each: CPU address and store data.
REQ-008 Port cpu_rdata, output, DBITS: load data returned to the CPU.
REQ-009 Port cpu_stall, output, 1: the CPU access was not performed; the pipeline holds this cycle.
REQ-010 Port dbg_req, input, 1: debug/loader request, held high until dbg_ack is seen.
REQ-011 Port dbg_wr, input, 1: the debug access is a write.
REQ-012 Port dbg_addr / dbg_wdata, input, DBITS each: debug address and write data.
REQ-013 Port dbg_ack, output, 1: one-cycle completion pulse for the debug access.
REQ-014 Port dbg_rdata, output, DBITS: registered debug read data, valid while dbg_ack=1.
REQ-015 Port mem_wrtEn, output, 1: write enable to DataMemory.
REQ-016 Port mem_addr / mem_dIn, output, DBITS each: address and write data to DataMemory.
REQ-017 Port mem_dOut, input, DBITS: combinational read data from DataMemory.
REQ-018 Port steal_cnt, output, 16: number of steal cycles taken since reset, saturating.

Function
REQ-019 FSM states: RUN and STEAL; the block also keeps a 4-bit wait_cnt and a 1-bit cooldown flag.
REQ-020 Grant is combinational from the current state and inputs; mem_addr, mem_dIn and mem_wrtEn come from the granted requester.
- No grant: mem_wrtEn=0 and mem_addr=cpu_addr.
REQ-021 RUN, cpu_req=1: CPU is granted; mem_wrtEn=cpu_wr; cpu_rdata=mem_dOut in the same cycle; cpu_stall=0.
REQ-022 RUN, cpu_req=0, dbg_req=1, cooldown=0: debug is granted (idle-slot grant); mem_wrtEn=dbg_wr.
REQ-023 Any debug grant in cycle N:
- dbg_ack=1 in cycle N+1.
- dbg_rdata = mem_dOut captured at the end of cycle N (written even when dbg_wr=1).
- cooldown=1 in cycle N+1.
- wait_cnt cleared.
REQ-024 cooldown=1 blocks any debug grant that cycle, so a requester that is still holding dbg_req during the ack cycle is not re-granted; cooldown clears after one cycle.
REQ-025 RUN with dbg_req=1, cooldown=0 and cpu_req=1 is a denied cycle: wait_cnt increments.
- When the incremented value equals MAX_WAIT, the next state is STEAL.
REQ-026 wait_cnt clears whenever dbg_req=0.
REQ-027 STEAL with dbg_req=1:
- Debug is granted.
- cpu_stall=1 regardless of cpu_req, and the CPU store is suppressed.
- steal_cnt increments, saturating at 16'hFFFF.
- Next state is RUN.
REQ-028 STEAL with dbg_req=0 (requester withdrew): behaves as RUN; no stall, no ack, no count; next state is RUN with wait_cnt=0.
REQ-029 cpu_stall shall be 0 in every state other than an active STEAL grant.
REQ-030 dbg_ack shall never assert in two consecutive cycles.
REQ-031 The maximum debug latency from dbg_req rising to dbg_ack is MAX_WAIT+2 cycles.
REQ-032 When cpu_req=0, cpu_rdata still equals mem_dOut; its value is don't-care.

Reset
REQ-033 While reset=0 at a clock edge, the next values are:
- state=RUN, wait_cnt=0, cooldown=0.
- dbg_ack=0, dbg_rdata=0, steal_cnt=0.
REQ-034 While reset=0, mem_wrtEn=0 and cpu_stall=0 combinationally, so no write reaches memory during reset.
REQ-035 Reset asserted during STEAL or during the ack cycle aborts the debug access:
- No dbg_ack is produced.
- Any write performed in the grant cycle before reset is not undone.

Verification
REQ-036 Idle-slot grant: cpu_req=0, dbg_req=1, dbg_wr=1, dbg_addr=0x40, dbg_wdata=0xDEADBEEF -> mem_wrtEn=1 at 0x40 in cycle N; dbg_ack=1 in N+1; no re-grant in N+1 while dbg_req is still high.
REQ-037 Starvation steal: MAX_WAIT=4, cpu_req=1 every cycle, dbg_req=1 read of 0x80 holding 0x12345678 -> four denied cycles, then cpu_stall=1 in the fifth cycle with mem_addr=0x80; dbg_ack=1 and dbg_rdata=0x12345678 in the sixth cycle; steal_cnt=1.
REQ-038 Store suppression: CPU store to 0x10 issued in the STEAL cycle -> mem_wrtEn follows dbg_wr (0 for a debug read), memory at 0x10 is unchanged, and cpu_stall=1.
REQ-039 Withdrawal: dbg_req drops in the cycle wait_cnt reaches MAX_WAIT -> no stall, no ack, wait_cnt=0.
REQ-040 Reset mid-steal: reset=0 during STEAL -> dbg_ack stays 0; state=RUN, steal_cnt=0, and mem_wrtEn=0 during reset.
REQ-041 Saturation: force 65 540 steals -> steal_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and DataMemory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int DBITS = 32
);
    logic             cpu_req;
    logic             cpu_wr;
    logic [DBITS-1:0] cpu_addr;
    logic [DBITS-1:0] cpu_wdata;
    logic [DBITS-1:0] cpu_rdata;
    logic             cpu_stall;

    logic             dbg_req;
    logic             dbg_wr;
    logic [DBITS-1:0] dbg_addr;
    logic [DBITS-1:0] dbg_wdata;
    logic             dbg_ack;
    logic [DBITS-1:0] dbg_rdata;

    logic             mem_wrtEn;
    logic [DBITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_dIn;
    logic [DBITS-1:0] mem_dOut;

    logic [15:0]      steal_cnt;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_wrtEn, mem_addr, mem_dIn,
        input  mem_dOut,
        output steal_cnt
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_wrtEn, mem_addr, mem_dIn,
        output mem_dOut,
        input  steal_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares DataMemory between the CPU and a debug port with starvation-bounded cycle stealing
module dmem_arbiter #(
    parameter int DBITS    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic {
        RUN   = 1'b0,
        STEAL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             cooldown_q, cooldown_d;
    logic             ack_q, ack_d;
    logic [DBITS-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [15:0]      steal_cnt_q, steal_cnt_d;

    logic       steal_grant;
    logic       dbg_grant;
    logic       cpu_grant;
    logic       denied;
    logic [3:0] wait_inc;

    // A withdrawn request in STEAL falls back to plain RUN arbitration.
    assign steal_grant = (state_q == STEAL) && bus.dbg_req;
    assign dbg_grant   = steal_grant || (!bus.cpu_req && bus.dbg_req && !cooldown_q);
    assign cpu_grant   = bus.cpu_req && !steal_grant;
    assign denied      = (state_q == RUN) && bus.cpu_req && bus.dbg_req && !cooldown_q;
    assign wait_inc    = wait_cnt_q + 4'd1;

    assign bus.mem_addr  = dbg_grant ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_dIn   = dbg_grant ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_wrtEn = reset && (dbg_grant ? bus.dbg_wr : (cpu_grant && bus.cpu_wr));
    assign bus.cpu_stall = reset && steal_grant;
    assign bus.cpu_rdata = bus.mem_dOut;

    // Gated so a reset landing in the ack cycle still suppresses the pulse.
    assign bus.dbg_ack   = ack_q && reset;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.steal_cnt = steal_cnt_q;

    always_comb begin
        state_d     = RUN;
        wait_cnt_d  = wait_cnt_q;
        cooldown_d  = dbg_grant;
        ack_d       = dbg_grant;
        dbg_rdata_d = dbg_rdata_q;
        steal_cnt_d = steal_cnt_q;

        if (!bus.dbg_req || dbg_grant) begin
            wait_cnt_d = 4'd0;
        end else if (denied) begin
            wait_cnt_d = wait_inc;
            if (wait_inc == 4'(MAX_WAIT)) begin
                state_d = STEAL;
            end
        end

        if (dbg_grant) begin
            dbg_rdata_d = bus.mem_dOut;
        end

        if (steal_grant && (steal_cnt_q != 16'hFFFF)) begin
            steal_cnt_d = steal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 4'd0;
            cooldown_q  <= 1'b0;
            ack_q       <= 1'b0;
            dbg_rdata_q <= '0;
            steal_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cooldown_q  <= cooldown_d;
            ack_q       <= ack_d;
            dbg_rdata_q <= dbg_rdata_d;
            steal_cnt_q <= steal_cnt_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - vector table plus debug-read scoreboard for dmem_arbiter
module tb_dmem_arbiter;
    localparam int MAXW = 4;

    typedef struct {
        logic        rst;
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        ew;
        logic [31:0] ea, ed;
        logic        es, ek;
        logic [15:0] est;
        logic        push;
        logic [31:0] edrd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] mem [0:255];
    logic [31:0] sb [$];
    vec_t tbl [$];
    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter_if #(.DBITS(32)) bus ();

    dmem_arbiter #(.DBITS(32), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_dOut = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_wrtEn) mem[bus.mem_addr[7:0]] <= bus.mem_dIn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rst, input logic cr, input logic cw,
                                 input logic [31:0] ca, input logic [31:0] cd,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd,
                                 input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                                 input logic es, input logic ek, input logic [15:0] est,
                                 input logic push, input logic [31:0] edrd);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ew = ew; v.ea = ea; v.ed = ed;
        v.es = es; v.ek = ek; v.est = est;
        v.push = push; v.edrd = edrd;
        return v;
    endfunction

    // CPU loads 0x20 every cycle while the debug port reads da and is refused
    task automatic add_denied(input int n, input logic [31:0] da, input logic [15:0] est);
        for (int i = 0; i < n; i++)
            tbl.push_back(mkv(1, 1, 0, 'h20, 0, 1, 0, da, 0, 0, 'h20, 0, 0, 0, est, 0, 0));
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] e;
        @(negedge clk);
        reset         = v.rst;
        bus.cpu_req   = v.cr;
        bus.cpu_wr    = v.cw;
        bus.cpu_addr  = v.ca;
        bus.cpu_wdata = v.cd;
        bus.dbg_req   = v.dr;
        bus.dbg_wr    = v.dw;
        bus.dbg_addr  = v.da;
        bus.dbg_wdata = v.dd;
        #1;
        chk($sformatf("r%0d_wrtEn", idx), 32'(bus.mem_wrtEn), 32'(v.ew));
        chk($sformatf("r%0d_addr", idx), bus.mem_addr, v.ea);
        if (v.ew) chk($sformatf("r%0d_dIn", idx), bus.mem_dIn, v.ed);
        chk($sformatf("r%0d_stall", idx), 32'(bus.cpu_stall), 32'(v.es));
        chk($sformatf("r%0d_ack", idx), 32'(bus.dbg_ack), 32'(v.ek));
        chk($sformatf("r%0d_steal_cnt", idx), 32'(bus.steal_cnt), 32'(v.est));
        if (bus.dbg_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL r%0d_unexpected_ack: got ack with rdata %h want no ack", idx, bus.dbg_rdata);
            end else begin
                e = sb.pop_front();
                chk($sformatf("r%0d_dbg_rdata", idx), bus.dbg_rdata, e);
            end
        end
        if (v.push) sb.push_back(v.edrd);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hCAFE0010;
        mem[8'h20] = 32'hA5A5A5A5;
        mem[8'h40] = 32'h11111111;
        mem[8'h80] = 32'h12345678;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_wr = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        repeat (2) @(posedge clk);

        // reset state, and no write reaches memory while reset is low
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 1, 'h20, 'h99, 0, 0, 0, 0, 0, 'h20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 0, 0, 0, 0, 0, 'h20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 1, 'h24, 'h24, 0, 0, 0, 0, 1, 'h24, 'h24, 0, 0, 0, 0, 0));
        // idle-slot debug write, no re-grant while held in the ack cycle
        tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 1, 'h40, 32'hDEADBEEF, 1, 'h40, 32'hDEADBEEF, 0, 0, 0, 1, 'h11111111));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 1, 'h40, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // starvation steal of a read at 0x80
        add_denied(MAXW, 'h80, 0);
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 1, 0, 'h80, 0, 0, 'h80, 0, 1, 0, 0, 1, 'h12345678));
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 1, 0, 'h80, 0, 0, 'h20, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 0, 0, 0, 0, 0, 'h20, 0, 0, 0, 1, 0, 0));
        // CPU store issued in the steal cycle is suppressed
        add_denied(MAXW, 'h40, 1);
        tbl.push_back(mkv(1, 1, 1, 'h10, 32'hFFFF0000, 1, 0, 'h40, 0, 0, 'h40, 0, 1, 0, 1, 1, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 0, 'h10, 0, 0, 0, 0, 0, 0, 'h10, 0, 0, 1, 2, 0, 0));
        // withdrawal in the steal cycle, then a full wait count from zero
        add_denied(MAXW, 'h80, 2);
        tbl.push_back(mkv(1, 1, 1, 'h24, 'h55, 0, 0, 0, 0, 1, 'h24, 'h55, 0, 0, 2, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        add_denied(MAXW, 'h80, 2);
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 1, 0, 'h80, 0, 0, 'h80, 0, 1, 0, 2, 1, 'h12345678));
        tbl.push_back(mkv(1, 1, 0, 'h20, 0, 0, 0, 0, 0, 0, 'h20, 0, 0, 1, 3, 0, 0));
        // reset in the steal cycle aborts the access
        add_denied(MAXW, 'h80, 3);
        tbl.push_back(mkv(0, 1, 1, 'h28, 'h77, 1, 0, 'h80, 0, 0, 'h80, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // memory contents seen through the CPU read path
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_wr = 0;
        bus.cpu_addr = 'h10; #1; chk("mem_0x10_unchanged", bus.cpu_rdata, 32'hCAFE0010);
        bus.cpu_addr = 'h40; #1; chk("mem_0x40_dbg_write", bus.cpu_rdata, 32'hDEADBEEF);
        bus.cpu_addr = 'h20; #1; chk("mem_0x20_reset_store", bus.cpu_rdata, 32'hA5A5A5A5);
        bus.cpu_addr = 'h24; #1; chk("mem_0x24_withdraw_store", bus.cpu_rdata, 32'h00000055);

        // latency from dbg_req rising to dbg_ack under continuous CPU traffic
        bus.cpu_addr = 'h20;
        bus.dbg_req = 1; bus.dbg_wr = 0; bus.dbg_addr = 'h80;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.dbg_ack) begin
                lat = i;
                break;
            end
        end
        chk("ack_latency", 32'(lat), 32'(MAXW + 1));
        chk("latency_rdata", bus.dbg_rdata, 32'h12345678);
        chk("latency_steal_cnt", 32'(bus.steal_cnt), 32'd1);
        bus.dbg_req = 0;

        // saturation: preload the counter just below the limit
        @(negedge clk);
        force dut.steal_cnt_q = 16'hFFFE;
        #1;
        release dut.steal_cnt_q;
        tbl.delete();
        for (int r = 0; r < 2; r++) begin
            add_denied(MAXW, 'h80, (r == 0) ? 16'hFFFE : 16'hFFFF);
            tbl.push_back(mkv(1, 1, 0, 'h20, 0, 1, 0, 'h80, 0, 0, 'h80, 0, 1, 0,
                              (r == 0) ? 16'hFFFE : 16'hFFFF, 1, 'h12345678));
            tbl.push_back(mkv(1, 1, 0, 'h20, 0, 0, 0, 0, 0, 0, 'h20, 0, 0, 1, 'hFFFF, 0, 0));
        end
        foreach (tbl[i]) apply(tbl[i], 100 + i);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
